// File: rtl/neuron_pkg.sv
// neuron_pkg: shared FSM states, activation encodings and saturating add for the neuron datapath
package neuron_pkg;

    typedef enum logic [2:0] {ACCUM, BIAS, LOOK, CAPT, OUT} state_t;

    typedef enum logic {ACT_SIGMOID = 1'b0, ACT_RELU = 1'b1} act_mode_t;

    // Operands arrive sign-extended to 64 bits; the result is clamped to a w-bit signed range.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [64:0] s, hi, lo;
        s  = a + b;
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -hi - 65'sd1;
        return 64'(s > hi ? hi : s < lo ? lo : s);
    endfunction

endpackage

// File: rtl/neuron_pipe_act_if.sv
// neuron_pipe_act_if: operand and result valid/ready bundle for one neuron
interface neuron_pipe_act_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] inp_data;
    logic signed [DATA_W-1:0] weight;
    logic signed [DATA_W-1:0] bias;
    logic                     act_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_data;
    logic [ACC_W-1:0]         out_acc;

    modport master (output in_valid, inp_data, weight, bias, act_mode, out_ready,
                    input  in_ready, out_valid, out_data, out_acc);
    modport slave  (input  in_valid, inp_data, weight, bias, act_mode, out_ready,
                    output in_ready, out_valid, out_data, out_acc);
endinterface

// File: rtl/neuron_act_unit.sv
// neuron_act_unit: sigmoid LUT address clamp and saturating ReLU rescale of the biased sum
module neuron_act_unit #(
    parameter int ACC_W      = 32,
    parameter int FRAC_W     = 8,
    parameter int LUT_ADDR_W = 12,
    parameter int LUT_FRAC_W = 7,
    parameter int OUT_W      = 8,
    parameter int OUT_FRAC_W = 4
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic [LUT_ADDR_W-1:0]   lut_addr,
    output logic [OUT_W-1:0]        relu
);
    localparam int LSH = 2*FRAC_W - LUT_FRAC_W;
    localparam int RSH = 2*FRAC_W - OUT_FRAC_W;
    localparam logic signed [ACC_W-1:0] HI   = ACC_W'((1 << (LUT_ADDR_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] LO   = ACC_W'(-HI - 1);
    localparam logic signed [ACC_W-1:0] OMAX = ACC_W'((1 << OUT_W) - 1);

    logic signed [ACC_W-1:0] s, r, off;

    // The LUT grid is centred: address 2^(LUT_ADDR_W-1) corresponds to zero.
    always_comb begin
        s        = acc >>> LSH;
        r        = acc >>> RSH;
        off      = s - LO;
        lut_addr = s > HI ? '1 : s < LO ? '0 : LUT_ADDR_W'(off);
        relu     = (acc[ACC_W-1] || acc == '0) ? '0 : r > OMAX ? OUT_W'(OMAX) : OUT_W'(r);
    end
endmodule

// File: rtl/neuron_pipe_act.sv
// neuron_pipe_act: valid/ready MAC neuron with saturating bias add and sigmoid-LUT or ReLU activation
module neuron_pipe_act
    import neuron_pkg::*;
#(
    parameter int N_INPUTS   = 784,
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int ACC_W      = 32,
    parameter int LUT_ADDR_W = 12,
    parameter int LUT_FRAC_W = 7,
    parameter int OUT_W      = 8,
    parameter int OUT_FRAC_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    neuron_pipe_act_if.slave      bus,
    output logic                  lut_rd_en,
    output logic [LUT_ADDR_W-1:0] lut_addr,
    input  logic [OUT_W-1:0]      lut_data
);
    localparam int CW = $clog2(N_INPUTS);

    state_t                     state;
    act_mode_t                  mode;
    logic [CW-1:0]              count;
    logic signed [ACC_W-1:0]    acc, biased;
    logic signed [DATA_W-1:0]   bias_q;
    logic signed [2*DATA_W-1:0] prod;
    logic [LUT_ADDR_W-1:0]      addr;
    logic [OUT_W-1:0]           relu;
    logic                       fire;

    assign fire   = bus.in_valid && bus.in_ready;
    assign prod   = bus.inp_data * bus.weight;
    // acc and bias_q are frozen from BIAS to OUT, so biased always equals out_acc there.
    assign biased = ACC_W'(sat_add(64'(acc), 64'(bias_q) <<< FRAC_W, ACC_W));

    neuron_act_unit #(
        .ACC_W(ACC_W), .FRAC_W(FRAC_W), .LUT_ADDR_W(LUT_ADDR_W),
        .LUT_FRAC_W(LUT_FRAC_W), .OUT_W(OUT_W), .OUT_FRAC_W(OUT_FRAC_W)
    ) u_act (
        .acc(biased), .lut_addr(addr), .relu(relu)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ACCUM;
            mode          <= ACT_SIGMOID;
            count         <= '0;
            acc           <= '0;
            bias_q        <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_acc   <= '0;
            lut_rd_en     <= 1'b0;
            lut_addr      <= '0;
        end else begin
            case (state)
                ACCUM: if (fire) begin
                    acc <= count == '0 ? ACC_W'(prod) : ACC_W'(sat_add(64'(acc), 64'(prod), ACC_W));
                    if (count == '0) mode <= act_mode_t'(bus.act_mode);
                    if (count == CW'(N_INPUTS - 1)) begin
                        count        <= '0;
                        bias_q       <= bus.bias;
                        bus.in_ready <= 1'b0;
                        state        <= BIAS;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                BIAS: begin
                    bus.out_acc <= biased;
                    lut_addr    <= addr;
                    lut_rd_en   <= mode == ACT_SIGMOID;
                    state       <= LOOK;
                end
                LOOK: begin
                    lut_rd_en <= 1'b0;
                    state     <= CAPT;
                end
                CAPT: begin
                    bus.out_data  <= mode == ACT_SIGMOID ? lut_data : relu;
                    bus.out_valid <= 1'b1;
                    state         <= OUT;
                end
                OUT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_pipe_act.sv
// tb_neuron_pipe_act: directed and random evaluations of a 4-input neuron against an arithmetic reference model
module tb_neuron_pipe_act;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        lut_rd_en;
    logic [11:0] lut_addr;
    logic [7:0]  lut_data = '0;
    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    logic [11:0] rd_addr = '0;
    logic signed [15:0] xv[N];
    logic signed [15:0] wv[N];

    neuron_pipe_act_if #(.DATA_W(16), .ACC_W(32), .OUT_W(8)) bus ();

    neuron_pipe_act #(.N_INPUTS(N)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .lut_rd_en(lut_rd_en), .lut_addr(lut_addr), .lut_data(lut_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lut_f(input logic [11:0] a);
        return a[11:4] ^ a[7:0] ^ 8'h3C;
    endfunction

    // Synchronous sigmoid ROM stand-in: data one cycle after the read strobe.
    always @(posedge clk) if (lut_rd_en) lut_data <= lut_f(lut_addr);

    always @(negedge clk) if (lut_rd_en) begin
        rd_cnt  = rd_cnt + 1;
        rd_addr = lut_addr;
    end

    function automatic longint sat32(input longint v);
        return v > 64'sd2147483647 ? 64'sd2147483647 : v < -64'sd2147483648 ? -64'sd2147483648 : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic signed [15:0] x, input logic signed [15:0] w);
        for (int i = 0; i < N; i++) begin
            xv[i] = x;
            wv[i] = w;
        end
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_acc", 64'(bus.out_acc), 64'd0);
        check("rst_lut_rd_en", 64'(lut_rd_en), 64'd0);
        check("rst_lut_addr", 64'(lut_addr), 64'd0);
    endtask

    // One full evaluation; mode/bias are driven with decoys on beats where they must be ignored.
    task automatic eval(input bit m, input logic signed [15:0] b, input int stall);
        longint a, bz, s, ea, ed;
        int     rd0, lat;
        a = 0;
        for (int i = 0; i < N; i++) begin
            longint p;
            p = longint'(xv[i]) * longint'(wv[i]);
            a = (i == 0) ? p : sat32(a + p);
        end
        bz = sat32(a + longint'(b) * 256);
        s  = bz >>> 9;
        ea = s > 2047 ? 4095 : s < -2048 ? 0 : s + 2048;
        if (m) ed = bz <= 0 ? 0 : (bz >>> 12) > 255 ? 255 : (bz >>> 12);
        else   ed = longint'(lut_f(12'(ea)));
        rd0 = rd_cnt;
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 1)) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.inp_data = xv[i];
            bus.weight   = wv[i];
            bus.act_mode = (i == 0) ? m : ~m;
            bus.bias     = (i == N-1) ? b : ~b;
            @(posedge clk); #1;
        end
        bus.inp_data = 16'($urandom);
        bus.weight   = 16'($urandom);
        bus.bias     = 16'($urandom);
        bus.act_mode = ~m;
        check("in_ready_low_after_last", 64'(bus.in_ready), 64'd0);
        lat = 0;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd3);
        check("out_acc", 64'(bus.out_acc), 64'(ea[31:0] | 32'h0) == 0 ? 64'(bz[31:0]) : 64'(bz[31:0]));
        check("out_data", 64'(bus.out_data), 64'(ed[7:0]));
        check("lut_rd_pulses", 64'(rd_cnt - rd0), m ? 64'd0 : 64'd1);
        if (!m) check("lut_addr", 64'(rd_addr), 64'(ea[11:0]));
        repeat (stall) begin
            @(posedge clk); #1;
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            check("stall_out_data", 64'(bus.out_data), 64'(ed[7:0]));
            check("stall_out_acc", 64'(bus.out_acc), 64'(bz[31:0]));
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("hs_out_valid", 64'(bus.out_valid), 64'd0);
        check("hs_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.inp_data  = '0;
        bus.weight    = '0;
        bus.bias      = '0;
        bus.act_mode  = 1'b0;
        bus.out_ready = 1'b0;
        #1 reset = 1'b1;
        #1 check_reset_values();
        @(posedge clk); #1;
        reset = 1'b0;

        set_ops(16'sh0100, 16'sh0100);
        eval(1'b0, 16'sh0000, 0);
        eval(1'b1, 16'sh0000, 0);
        set_ops(16'sh0100, -16'sh0100);
        eval(1'b0, -16'sh0080, 0);
        eval(1'b1, -16'sh0080, 0);
        set_ops(16'sh7F00, 16'sh0400);
        eval(1'b1, 16'sh0000, 0);
        eval(1'b0, 16'sh0000, 0);
        set_ops(16'sh7FFF, 16'sh7FFF);
        eval(1'b0, 16'sh0000, 0);
        set_ops(16'sh0230, -16'sh0090);
        eval(1'b1, 16'sh0300, 5);

        // Abort an evaluation after two beats; the next run must start from a clean count.
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.inp_data = 16'sh7FFF;
            bus.weight   = 16'sh7FFF;
            bus.act_mode = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1 check_reset_values();
        @(posedge clk); #1;
        reset = 1'b0;
        set_ops(16'sh0100, 16'sh0100);
        eval(1'b1, 16'sh0010, 0);

        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N; i++) begin
                xv[i] = 16'($urandom);
                xv[i] = xv[i] >>> $urandom_range(0, 8);
                wv[i] = 16'($urandom);
                wv[i] = wv[i] >>> $urandom_range(0, 8);
            end
            eval(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
